// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter that shares one UART TX serializer among NUM_REQ byte sources.
// A stall timeout recovers the lock from an owner that stops sending mid-message.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1024,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_valid,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_ready,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy,
    output logic                      timeout_pulse
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]  stall_cnt;

    logic              owner_valid;
    logic              owner_last;
    logic [DATA_W-1:0] owner_data;
    logic              pick_found;
    logic [ID_W-1:0]   pick_id;
    logic [ID_W-1:0]   next_ptr;
    logic [ID_W:0]     scan_sum;
    logic [ID_W-1:0]   scan_idx;

    // Mux the current owner's stream onto the serializer side.
    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = '0;
        req_ready   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                owner_valid = req_valid[i];
                owner_last  = req_last[i];
                owner_data  = req_data[i*DATA_W +: DATA_W];
                req_ready[i] = (state == LOCKED) & tx_ready;
            end
        end
    end

    assign busy     = (state == LOCKED);
    assign tx_valid = busy & owner_valid;
    assign tx_data  = owner_data;
    assign next_ptr = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

    // Scan offsets from the far end inward so the requester closest to rr_ptr wins.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = rr_ptr;
        scan_sum   = '0;
        scan_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (scan_sum >= (ID_W+1)'(NUM_REQ)) begin
                scan_sum = scan_sum - (ID_W+1)'(NUM_REQ);
            end
            scan_idx = scan_sum[ID_W-1:0];
            for (int i = 0; i < NUM_REQ; i++) begin
                if (scan_idx == ID_W'(i) && req_valid[i]) begin
                    pick_found = 1'b1;
                    pick_id    = scan_idx;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            grant_id      <= '0;
            stall_cnt     <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    stall_cnt <= '0;
                    if (pick_found) begin
                        grant_id <= pick_id;
                        state    <= LOCKED;
                    end
                end
                LOCKED: begin
                    // Backpressure keeps the counter clear: only a silent owner can time out.
                    if (owner_valid) begin
                        stall_cnt <= '0;
                        if (tx_ready && owner_last) begin
                            state  <= IDLE;
                            rr_ptr <= next_ptr;
                        end
                    end else if (stall_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state         <= IDLE;
                        rr_ptr        <= next_ptr;
                        stall_cnt     <= '0;
                        timeout_pulse <= 1'b1;
                    end else begin
                        stall_cnt <= stall_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter with two requesters and a short stall timeout.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_uart_tx_arbiter;

    localparam int TIMEOUT = 16;

    logic        clock;
    logic        reset;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [0:0]  grant_id;
    logic        busy;
    logic        timeout_pulse;

    int checkCount = 0;
    int passCount  = 0;

    uart_tx_arbiter #(
        .NUM_REQ (2),
        .DATA_W  (8),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_ready      (tx_ready),
        .grant_id      (grant_id),
        .busy          (busy),
        .timeout_pulse (timeout_pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Guards against a hung run so the bench always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passCount, checkCount);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic [7:0] d0, input logic [7:0] d1,
                                 input logic [1:0] last, input logic ready);
        req_valid = valid;
        req_data  = {d1, d0};
        req_last  = last;
        tx_ready  = ready;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(2'b00, 8'h00, 8'h00, 2'b00, 1'b1);
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int badCycles;
        int pulseAt;
        int leakCycles;

        reset = 1'b1;
        applyStimulus(2'b00, 8'h00, 8'h00, 2'b00, 1'b0);
        doReset();

        // Reset state
        sample();
        checkOutput("reset busy", busy, 0);
        checkOutput("reset tx_valid", tx_valid, 0);
        checkOutput("reset grant_id", grant_id, 0);
        checkOutput("reset req_ready", req_ready, 0);
        checkOutput("reset timeout_pulse", timeout_pulse, 0);

        // Test 1: single 3-byte message from req0
        tick();
        applyStimulus(2'b01, 8'h48, 8'h00, 2'b00, 1'b1);
        sample();
        checkOutput("t1 idle tx_valid", tx_valid, 0);
        checkOutput("t1 idle req_ready", req_ready, 0);
        tick();
        sample();
        checkOutput("t1 grant busy", busy, 1);
        checkOutput("t1 grant id", grant_id, 0);
        checkOutput("t1 byte0 valid", tx_valid, 1);
        checkOutput("t1 byte0 data", tx_data, 8'h48);
        checkOutput("t1 byte0 ready", req_ready, 2'b01);
        tick();
        applyStimulus(2'b01, 8'h69, 8'h00, 2'b00, 1'b1);
        sample();
        checkOutput("t1 byte1 valid", tx_valid, 1);
        checkOutput("t1 byte1 data", tx_data, 8'h69);
        tick();
        applyStimulus(2'b01, 8'h0A, 8'h00, 2'b01, 1'b1);
        sample();
        checkOutput("t1 byte2 data", tx_data, 8'h0A);
        checkOutput("t1 byte2 busy", busy, 1);
        tick();
        applyStimulus(2'b00, 8'h00, 8'h00, 2'b00, 1'b1);
        sample();
        checkOutput("t1 after last busy", busy, 0);
        checkOutput("t1 after last tx_valid", tx_valid, 0);
        // rr_ptr is now 1, so contention must go to req1
        applyStimulus(2'b11, 8'h11, 8'h22, 2'b11, 1'b1);
        tick();
        sample();
        checkOutput("t1 rr_ptr grant", grant_id, 1);
        checkOutput("t1 rr_ptr data", tx_data, 8'h22);
        checkOutput("t1 rr_ptr ready", req_ready, 2'b10);
        tick();
        applyStimulus(2'b00, 8'h00, 8'h00, 2'b00, 1'b1);

        // Test 2: contention after reset alternates between requesters
        doReset();
        applyStimulus(2'b11, 8'hA0, 8'hB0, 2'b00, 1'b1);
        tick();
        sample();
        checkOutput("t2 first grant", grant_id, 0);
        checkOutput("t2 A0", tx_data, 8'hA0);
        checkOutput("t2 req1 held off", req_ready, 2'b01);
        tick();
        applyStimulus(2'b11, 8'hA1, 8'hB0, 2'b01, 1'b1);
        sample();
        checkOutput("t2 A1", tx_data, 8'hA1);
        tick();
        applyStimulus(2'b10, 8'h00, 8'hB0, 2'b00, 1'b1);
        sample();
        checkOutput("t2 gap busy", busy, 0);
        checkOutput("t2 gap tx_valid", tx_valid, 0);
        tick();
        sample();
        checkOutput("t2 second grant", grant_id, 1);
        checkOutput("t2 B0", tx_data, 8'hB0);
        tick();
        applyStimulus(2'b10, 8'h00, 8'hB1, 2'b10, 1'b1);
        sample();
        checkOutput("t2 B1", tx_data, 8'hB1);
        tick();
        applyStimulus(2'b11, 8'hC0, 8'hD0, 2'b11, 1'b1);
        sample();
        checkOutput("t2 gap2 busy", busy, 0);
        tick();
        sample();
        checkOutput("t2 repeat grant", grant_id, 0);
        checkOutput("t2 C0", tx_data, 8'hC0);
        tick();
        applyStimulus(2'b00, 8'h00, 8'h00, 2'b00, 1'b1);
        sample();

        // Test 3: req1 shows up mid-message and must wait for req0's last byte
        applyStimulus(2'b01, 8'h50, 8'h00, 2'b00, 1'b1);
        tick();
        badCycles = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus((i >= 1) ? 2'b11 : 2'b01, 8'h50 + 8'(i), 8'hEE, (i == 4) ? 2'b11 : 2'b10, 1'b1);
            sample();
            if (tx_data !== 8'h50 + 8'(i) || req_ready[1] !== 1'b0 || grant_id !== 1'b0 || tx_valid !== 1'b1) begin
                badCycles++;
            end
            tick();
        end
        checkOutput("t3 req0 burst bad cycles", badCycles, 0);
        applyStimulus(2'b10, 8'h00, 8'hEE, 2'b10, 1'b1);
        sample();
        checkOutput("t3 gap busy", busy, 0);
        tick();
        sample();
        checkOutput("t3 req1 grant", grant_id, 1);
        checkOutput("t3 req1 data", tx_data, 8'hEE);
        tick();
        applyStimulus(2'b00, 8'h00, 8'h00, 2'b00, 1'b1);
        sample();

        // Test 4: long UART backpressure must never trigger the stall timeout
        applyStimulus(2'b01, 8'h77, 8'h00, 2'b01, 1'b0);
        tick();
        badCycles = 0;
        for (int i = 0; i < 2000; i++) begin
            sample();
            if (tx_data !== 8'h77 || tx_valid !== 1'b1 || busy !== 1'b1 || timeout_pulse !== 1'b0 || req_ready !== 2'b00) begin
                badCycles++;
            end
            tick();
        end
        checkOutput("t4 backpressure bad cycles", badCycles, 0);
        tx_ready = 1'b1;
        sample();
        checkOutput("t4 release ready", req_ready, 2'b01);
        tick();
        applyStimulus(2'b00, 8'h00, 8'h00, 2'b00, 1'b1);
        sample();
        checkOutput("t4 done busy", busy, 0);
        checkOutput("t4 no pulse", timeout_pulse, 0);

        // Test 5: owner goes silent mid-message and the lock is reclaimed after TIMEOUT cycles
        applyStimulus(2'b01, 8'h41, 8'h00, 2'b00, 1'b1);
        tick();
        sample();
        checkOutput("t5 grant", grant_id, 0);
        checkOutput("t5 41", tx_data, 8'h41);
        tick();
        applyStimulus(2'b10, 8'h41, 8'h99, 2'b10, 1'b1);
        pulseAt    = 0;
        leakCycles = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            sample();
            if (timeout_pulse === 1'b1) begin
                pulseAt = n;
                break;
            end
            if (tx_valid !== 1'b0 || req_ready[1] !== 1'b0) begin
                leakCycles++;
            end
        end
        checkOutput("t5 pulse delay", pulseAt, TIMEOUT);
        checkOutput("t5 no traffic while stalled", leakCycles, 0);
        checkOutput("t5 released busy", busy, 0);
        tick();
        sample();
        checkOutput("t5 pulse width", timeout_pulse, 0);
        checkOutput("t5 req1 grant", grant_id, 1);
        checkOutput("t5 req1 data", tx_data, 8'h99);
        tick();
        applyStimulus(2'b00, 8'h00, 8'h00, 2'b00, 1'b1);
        sample();

        // Test 6: reset during req1's second byte aborts the message
        applyStimulus(2'b10, 8'h00, 8'h61, 2'b00, 1'b1);
        tick();
        sample();
        checkOutput("t6 grant", grant_id, 1);
        checkOutput("t6 byte1", tx_data, 8'h61);
        tick();
        applyStimulus(2'b10, 8'h00, 8'h62, 2'b00, 1'b1);
        sample();
        checkOutput("t6 byte2", tx_data, 8'h62);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(2'b11, 8'h71, 8'h62, 2'b00, 1'b1);
        sample();
        checkOutput("t6 reset tx_valid", tx_valid, 0);
        checkOutput("t6 reset busy", busy, 0);
        checkOutput("t6 reset grant_id", grant_id, 0);
        tick();
        sample();
        checkOutput("t6 contention grant", grant_id, 0);
        checkOutput("t6 contention data", tx_data, 8'h71);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
